// File: rtl/qpsk_mod_if.sv
// Symbol/control and sample-stream bundle for the QPSK modulator.
// The master drives the symbol rails and run enable; the slave returns samples.
interface qpsk_mod_if #(
  parameter int OUT_W = 10
);
  logic                    mod_en;
  logic [1:0]              I;
  logic [1:0]              Q;
  logic signed [OUT_W-1:0] mod_out;
  logic                    carrier_sync;

  modport master (output mod_en, I, Q, input mod_out, carrier_sync);
  modport slave  (input mod_en, I, Q, output mod_out, carrier_sync);
endinterface

// File: rtl/qpsk_mod.sv
// QPSK modulator: DDS carrier with quarter-wave sine ROM, three-stage pipeline
// producing mod_out = I*cos(wt) + Q*sin(wt) plus a phase-zero sync pulse.
module qpsk_mod #(
  parameter logic [31:0] FREQ_WORD = 32'd4294967,
  parameter int          AMP_W     = 8,
  parameter int          OUT_W     = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  qpsk_mod_if.slave bus
);

  // round(127*sin(2*pi*k/256)), k = 0..64
  localparam logic [6:0] SINE_ROM [0:64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
    7'd127
  };

  function automatic logic signed [AMP_W-1:0] wave(input logic [7:0] ph);
    logic [6:0]              idx;
    logic signed [AMP_W-1:0] mag;
    idx = ph[6] ? (7'd64 - {1'b0, ph[5:0]}) : {1'b0, ph[5:0]};
    mag = '0;
    mag[6:0] = SINE_ROM[idx];
    return ph[7] ? -mag : mag;
  endfunction

  logic [31:0]             phase_acc;
  logic [7:0]              p;
  logic [7:0]              p_cos;
  logic signed [AMP_W-1:0] sin_r, cos_r;
  logic                    i_s, q_s;
  logic signed [OUT_W-1:0] sin_x, cos_x;
  logic signed [OUT_W-1:0] prod_i, prod_q;
  logic signed [OUT_W-1:0] mod_out_r;
  logic                    sync1, sync2, sync3;

  assign p     = phase_acc[31:24];
  assign p_cos = p + 8'd64;
  assign sin_x = {{(OUT_W-AMP_W){sin_r[AMP_W-1]}}, sin_r};
  assign cos_x = {{(OUT_W-AMP_W){cos_r[AMP_W-1]}}, cos_r};

  // Dropping mod_en is a phase reset only; the pipeline keeps draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc <= '0;
    end else if (!bus.mod_en) begin
      phase_acc <= '0;
    end else begin
      phase_acc <= phase_acc + FREQ_WORD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_r     <= '0;
      cos_r     <= '0;
      i_s       <= 1'b0;
      q_s       <= 1'b0;
      sync1     <= 1'b0;
      prod_i    <= '0;
      prod_q    <= '0;
      sync2     <= 1'b0;
      mod_out_r <= '0;
      sync3     <= 1'b0;
    end else begin
      sin_r     <= wave(p);
      cos_r     <= wave(p_cos);
      i_s       <= bus.I[1];
      q_s       <= bus.Q[1];
      sync1     <= (p == 8'd0);
      prod_i    <= i_s ? -cos_x : cos_x;
      prod_q    <= q_s ? -sin_x : sin_x;
      sync2     <= sync1;
      mod_out_r <= prod_i + prod_q;
      sync3     <= sync2;
    end
  end

  assign bus.mod_out      = mod_out_r;
  assign bus.carrier_sync = sync3;

endmodule
